// File: rtl/mbist_mem_collar.sv
// rtl/mbist_mem_collar.sv - MBIST memory collar arbitrating a register-array SRAM between functional and BIST ports
// Optional read-path stuck-at fault injection: define MBIST_FAULT_INJECT_EN.
module mbist_mem_collar #(
    parameter int  ADDR_WIDTH = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  CNT_WIDTH  = 8,
    localparam int DEPTH      = 2 ** ADDR_WIDTH,
    localparam int BIT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bist_mode,
    output logic                  bist_active,
    input  logic                  fn_en,
    input  logic                  fn_we,
    input  logic [ADDR_WIDTH-1:0] fn_addr,
    input  logic [DATA_WIDTH-1:0] fn_wdata,
    output logic [DATA_WIDTH-1:0] fn_rdata,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [CNT_WIDTH-1:0]  acc_cnt,
    input  logic                  fi_en,
    input  logic [ADDR_WIDTH-1:0] fi_addr,
    input  logic [BIT_WIDTH-1:0]  fi_bit,
    input  logic                  fi_val
);

    typedef enum logic [1:0] {
        ST_FUNC,
        ST_BIST,
        ST_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic                    bist_active_q, bist_active_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [DATA_WIDTH-1:0]   fn_rdata_q, fn_rdata_d;
    logic [CNT_WIDTH-1:0]    acc_cnt_q, acc_cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign req_ready = (state_q == ST_BIST) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

`ifdef MBIST_FAULT_INJECT_EN
    // Stuck-at is applied on the BIST read path only; the stored word stays intact.
    always_comb begin
        rd_word = mem_q[req_addr];
        if (fi_en && (fi_addr == req_addr)) begin
            rd_word[fi_bit] = fi_val;
        end
    end
`else
    logic unused_fi;
    assign unused_fi = ^{fi_en, fi_addr, fi_bit, fi_val};
    assign rd_word   = mem_q[req_addr];
`endif

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        fn_rdata_d  = fn_rdata_q;
        acc_cnt_d   = acc_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = req_addr;
        mem_wdata   = req_wdata;

        if (accept && (acc_cnt_q != {CNT_WIDTH{1'b1}})) begin
            acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
        end
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (accept) begin
            if (req_we) begin
                mem_we = 1'b1;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd_word;
            end
        end

        case (state_q)
            ST_FUNC: begin
                if (fn_en) begin
                    if (fn_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = fn_addr;
                        mem_wdata = fn_wdata;
                    end else begin
                        fn_rdata_d = mem_q[fn_addr];
                    end
                end
                if (bist_mode) begin
                    state_d = ST_BIST;
                end
            end
            // Leaving BIST with a response still owed (including one accepted this cycle) must drain first.
            ST_BIST: begin
                if (!bist_mode) begin
                    state_d = rsp_valid_d ? ST_DRAIN : ST_FUNC;
                end
            end
            ST_DRAIN: begin
                if (!rsp_valid_d) begin
                    state_d = ST_FUNC;
                end
            end
            default: state_d = ST_FUNC;
        endcase

        bist_active_d = (state_d != ST_FUNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FUNC;
            bist_active_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            fn_rdata_q    <= '0;
            acc_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            bist_active_q <= bist_active_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            fn_rdata_q    <= fn_rdata_d;
            acc_cnt_q     <= acc_cnt_d;
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bist_active = bist_active_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign fn_rdata    = fn_rdata_q;
    assign acc_cnt     = acc_cnt_q;

endmodule

// File: tb/tb_mbist_mem_collar.sv
// tb/tb_mbist_mem_collar.sv - randomized self-checking bench for mbist_mem_collar against a behavioural model
module tb_mbist_mem_collar;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 8;
`ifdef MBIST_FAULT_INJECT_EN
    localparam logic [7:0] FI_EXP = 8'h01;
`else
    localparam logic [7:0] FI_EXP = 8'h00;
`endif

    logic          clk;
    logic          rst;
    logic          bist_mode;
    logic          bist_active;
    logic          fn_en;
    logic          fn_we;
    logic [AW-1:0] fn_addr;
    logic [DW-1:0] fn_wdata;
    logic [DW-1:0] fn_rdata;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] acc_cnt;
    logic          fi_en;
    logic [AW-1:0] fi_addr;
    logic [2:0]    fi_bit;
    logic          fi_val;

    mbist_mem_collar #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bist_mode  (bist_mode),
        .bist_active(bist_active),
        .fn_en      (fn_en),
        .fn_we      (fn_we),
        .fn_addr    (fn_addr),
        .fn_wdata   (fn_wdata),
        .fn_rdata   (fn_rdata),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .acc_cnt    (acc_cnt),
        .fi_en      (fi_en),
        .fi_addr    (fi_addr),
        .fi_bit     (fi_bit),
        .fi_val     (fi_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int npop  = 0;

    // Reference model: memory image, owed responses, ownership mode (0 func, 1 bist, 2 drain).
    logic [7:0] m_mem [16];
    logic [7:0] exp_q [$];
    int         m_state;
    int         m_acc;
    logic [7:0] m_fn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bist_read(input logic [3:0] a);
        logic [7:0] v;
        v = m_mem[a];
`ifdef MBIST_FAULT_INJECT_EN
        if (fi_en && (fi_addr == a)) v[fi_bit] = fi_val;
`endif
        return v;
    endfunction

    task automatic tick();
        bit exp_ready;
        bit acc;
        @(negedge clk);
        exp_ready = (m_state == 1) && ((exp_q.size() == 0) || rsp_ready);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("bist_active", 32'(bist_active), 32'(m_state != 0));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        check("acc_cnt", 32'(acc_cnt), (m_acc > 255) ? 32'd255 : 32'(m_acc));
        check("fn_rdata", 32'(fn_rdata), 32'(m_fn));
        if (exp_q.size() != 0) check("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
        if (rst) begin
            exp_q.delete();
            m_state = 0;
            m_acc   = 0;
            m_fn    = 8'h00;
        end else begin
            acc = exp_ready && req_valid;
            if ((exp_q.size() != 0) && rsp_ready) begin
                void'(exp_q.pop_front());
                npop++;
            end
            if (acc) begin
                m_acc++;
                if (req_we) m_mem[req_addr] = req_wdata;
                else exp_q.push_back(bist_read(req_addr));
            end
            if ((m_state == 0) && fn_en) begin
                if (fn_we) m_mem[fn_addr] = fn_wdata;
                else m_fn = m_mem[fn_addr];
            end
            case (m_state)
                0: if (bist_mode) m_state = 1;
                1: if (!bist_mode) m_state = (exp_q.size() != 0) ? 2 : 0;
                default: if (exp_q.size() == 0) m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bist_req(input logic we, input logic [3:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] a_sel;
        logic [7:0] held;
        rst = 1'b1; bist_mode = 1'b0;
        fn_en = 1'b0; fn_we = 1'b0; fn_addr = '0; fn_wdata = '0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        fi_en = 1'b0; fi_addr = '0; fi_bit = '0; fi_val = 1'b0;
        m_state = 0; m_acc = 0; m_fn = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bist_active", 32'(bist_active), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_fn_rdata", 32'(fn_rdata), 32'd0);
        check("rst_acc_cnt", 32'(acc_cnt), 32'd0);
        rst = 1'b0;

        // Fill with 0x05 then read every word back at full throughput.
        bist_mode = 1'b1;
        rsp_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) bist_req(1'b1, 4'(i), 8'h05);
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            tick();
        end
        req_valid = 1'b0;
        tick();
        check("fill_acc_cnt", 32'(acc_cnt), 32'd32);
        check("fill_rsp_count", 32'(npop), 32'd16);

        // Back-pressure on a read of address 3.
        rsp_ready = 1'b0;
        bist_req(1'b0, 4'd3, 8'h00);
        held = rsp_data;
        repeat (4) tick();
        check("bp_rsp_data_stable", 32'(rsp_data), 32'(held));
        check("bp_req_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        #1;
        check("bp_req_ready_comb", 32'(req_ready), 32'd1);
        tick();

        // Write then immediate read of the same address.
        a_sel = 4'($urandom_range(0, 15));
        bist_req(1'b1, a_sel, 8'hA5);
        bist_req(1'b0, a_sel, 8'h00);
        check("wr_rd_data", 32'(rsp_data), 32'hA5);
        tick();

        // Drop bist_mode with an unconsumed read: must drain before returning to FUNC.
        rsp_ready = 1'b0;
        bist_req(1'b0, 4'd9, 8'h00);
        bist_mode = 1'b0;
        repeat (3) tick();
        check("drain_active", 32'(bist_active), 32'd1);
        rsp_ready = 1'b1;
        tick();
        tick();
        check("drain_to_func", 32'(bist_active), 32'd0);

        // Functional traffic; BIST requests must be ignored.
        for (int i = 0; i < 40; i++) begin
            fn_en     = 1'($urandom);
            fn_we     = 1'($urandom);
            fn_addr   = 4'($urandom);
            fn_wdata  = 8'($urandom);
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_addr  = 4'($urandom);
            tick();
        end
        req_valid = 1'b0;

        // Fully random mixed traffic, including mode changes and fault-inject controls.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) bist_mode = ~bist_mode;
            fn_en     = 1'($urandom);
            fn_we     = 1'($urandom);
            fn_addr   = 4'($urandom);
            fn_wdata  = 8'($urandom);
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_addr  = 4'($urandom);
            req_wdata = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            fi_en     = 1'($urandom);
            fi_addr   = 4'($urandom);
            fi_bit    = 3'($urandom);
            fi_val    = 1'($urandom);
            tick();
        end
        fn_en = 1'b0; req_valid = 1'b0; fi_en = 1'b0; rsp_ready = 1'b1;

        // Saturation after 300 accepts from a clean reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bist_mode = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom);
            req_addr  = 4'($urandom);
            req_wdata = 8'($urandom);
            tick();
        end
        req_valid = 1'b0;
        tick();
        check("acc_saturated", 32'(acc_cnt), 32'd255);

        // Reset while a read response is pending.
        rsp_ready = 1'b0;
        bist_req(1'b0, 4'd5, 8'h00);
        bist_mode = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_state", 32'(bist_active), 32'd0);
        rsp_ready = 1'b1;
        tick();

        // Read-path fault injection on address 7, bit 0 forced high.
        bist_mode = 1'b1;
        tick();
        fi_en = 1'b1; fi_addr = 4'd7; fi_bit = 3'd0; fi_val = 1'b1;
        bist_req(1'b1, 4'd7, 8'h00);
        bist_req(1'b0, 4'd7, 8'h00);
        check("fi_bist_read", 32'(rsp_data), 32'(FI_EXP));
        bist_mode = 1'b0;
        repeat (2) tick();
        fn_en = 1'b1; fn_we = 1'b0; fn_addr = 4'd7;
        tick();
        fn_en = 1'b0;
        check("fi_func_read", 32'(fn_rdata), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
